// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder.
package adder_ctrl_pkg;
  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/nibble_serial_adder_ctrl_if.sv
// Request/response bundle for the nibble-serial adder.
interface nibble_serial_adder_ctrl_if #(
  parameter int N_NIBBLES = 4
) ();
  logic                   i_valid;
  logic                   o_ready;
  logic [4*N_NIBBLES-1:0] i_a;
  logic [4*N_NIBBLES-1:0] i_b;
  logic                   c_in;
  logic                   o_valid;
  logic                   i_ready;
  logic [4*N_NIBBLES-1:0] o_sum;
  logic                   c_out;

  modport master (
    output i_valid, i_a, i_b, c_in, i_ready,
    input  o_ready, o_valid, o_sum, c_out
  );

  modport slave (
    input  i_valid, i_a, i_b, c_in, i_ready,
    output o_ready, o_valid, o_sum, c_out
  );
endinterface

// File: rtl/nibble_serial_adder_ctrl_four_bits.sv
// Four-bit carry-select adder slice: both carry outcomes precomputed, cin picks.
module four_bits
  import adder_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout
);
  logic [NIBBLE_W:0] sum0, sum1;

  assign sum0 = {1'b0, a} + {1'b0, b};
  assign sum1 = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, 1'b1};

  assign {cout, s} = cin ? sum1 : sum0;
endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial adder: captures operands, adds one nibble per cycle on a
// single shared slice, then holds the result until downstream accepts it.
module nibble_serial_adder_ctrl
  import adder_ctrl_pkg::*;
#(
  parameter int N_NIBBLES = 4
) (
  input logic                       clk,
  input logic                       rst,
  nibble_serial_adder_ctrl_if.slave bus
);
  localparam int W     = NIBBLE_W * N_NIBBLES;
  localparam int IDX_W = $clog2(N_NIBBLES) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NIBBLES - 1);

  state_e              state_q, state_d;
  logic [W-1:0]        a_q, b_q, sum_q;
  logic                cin_q, carry_q, cout_q;
  logic [IDX_W-1:0]    idx_q;
  logic [NIBBLE_W-1:0] nib_a, nib_b, nib_s;
  logic                slice_cin, slice_cout;
  logic                accept, last;

  assign accept = bus.i_valid && (state_q == IDLE);
  assign last   = (idx_q == LAST_IDX);

  // Route the current nibble of the captured operands to the slice.
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int k = 0; k < N_NIBBLES; k++) begin
      if (idx_q == IDX_W'(k)) begin
        nib_a = a_q[k*NIBBLE_W +: NIBBLE_W];
        nib_b = b_q[k*NIBBLE_W +: NIBBLE_W];
      end
    end
    slice_cin = (idx_q == '0) ? cin_q : carry_q;
  end

  four_bits u_slice (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (slice_cin),
    .s    (nib_s),
    .cout (slice_cout)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: accept in IDLE, finish on last nibble, release on i_ready.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)      state_d = RUN;
      RUN:     if (last)        state_d = DONE;
      DONE:    if (bus.i_ready) state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  // Operand capture, per-nibble result write-back and carry chaining.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else if (accept) begin
      a_q   <= bus.i_a;
      b_q   <= bus.i_b;
      cin_q <= bus.c_in;
      idx_q <= '0;
    end else if (state_q == RUN) begin
      for (int k = 0; k < N_NIBBLES; k++)
        if (idx_q == IDX_W'(k)) sum_q[k*NIBBLE_W +: NIBBLE_W] <= nib_s;
      carry_q <= slice_cout;
      idx_q   <= idx_q + IDX_W'(1);
      if (last) cout_q <= slice_cout;
    end
  end

  assign bus.o_ready = (state_q == IDLE);
  assign bus.o_valid = (state_q == DONE);
  assign bus.o_sum   = sum_q;
  assign bus.c_out   = cout_q;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench: 4-nibble instance for carry/backpressure/reset/ignore cases,
// 1-nibble instance for the full 512-case sweep.
module tb_nibble_serial_adder_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  nibble_serial_adder_ctrl_if #(.N_NIBBLES(4)) b4 ();
  nibble_serial_adder_ctrl_if #(.N_NIBBLES(1)) b1 ();

  nibble_serial_adder_ctrl #(.N_NIBBLES(4)) dut4 (.clk(clk), .rst(rst), .bus(b4.slave));
  nibble_serial_adder_ctrl #(.N_NIBBLES(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive a request now (caller aligns to a negedge), wait for o_valid and
  // check latency and result; leaves the DUT in DONE.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic [15:0] es, input logic ec,
                        input bit perturb);
    int lat;
    chk({tag, "_rdy"}, 32'(b4.o_ready), 32'd1);
    b4.i_a = a; b4.i_b = b; b4.c_in = cin; b4.i_valid = 1'b1;
    @(posedge clk); #1;
    b4.i_valid = 1'b0;
    lat = 0;
    while (!b4.o_valid && lat < 20) begin
      if (perturb) begin
        b4.i_a     = 16'($urandom);
        b4.i_b     = 16'($urandom);
        b4.c_in    = ~b4.c_in;
        b4.i_valid = (lat == 1);
      end
      chk({tag, "_busy"}, 32'(b4.o_ready), 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    b4.i_valid = 1'b0;
    chk({tag, "_lat"}, 32'(lat), 32'd4);
    chk({tag, "_sum"}, 32'(b4.o_sum), 32'(es));
    chk({tag, "_cout"}, 32'(b4.c_out), 32'(ec));
  endtask

  // Release DONE with i_ready and confirm return to IDLE with result retained.
  task automatic release_done(input string tag, input logic [15:0] es, input logic ec);
    b4.i_ready = 1'b1;
    @(posedge clk); #1;
    b4.i_ready = 1'b0;
    chk({tag, "_vld_fall"}, 32'(b4.o_valid), 32'd0);
    chk({tag, "_idle"}, 32'(b4.o_ready), 32'd1);
    chk({tag, "_keep"}, {15'd0, ec, b4.o_sum}, {15'd0, b4.c_out, es});
  endtask

  initial begin
    bit seen;
    b4.i_valid = 0; b4.i_a = 0; b4.i_b = 0; b4.c_in = 0; b4.i_ready = 0;
    b1.i_valid = 0; b1.i_a = 0; b1.i_b = 0; b1.c_in = 0; b1.i_ready = 0;

    // Reset state, observed before any clock edge.
    #1;
    chk("rst_rdy", 32'(b4.o_ready), 32'd1);
    chk("rst_vld", 32'(b4.o_valid), 32'd0);
    chk("rst_sum", 32'(b4.o_sum), 32'd0);
    chk("rst_cout", 32'(b4.c_out), 32'd0);

    // First request on the first edge after reset release.
    @(negedge clk); rst = 1'b0;
    run_op("carry", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    release_done("carry", 16'h0000, 1'b1);

    @(negedge clk);
    run_op("cin1", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);
    release_done("cin1", 16'h5556, 1'b0);

    @(negedge clk);
    run_op("cin2", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    release_done("cin2", 16'hFFFF, 1'b1);

    @(negedge clk);
    run_op("mix", 16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0);
    release_done("mix", 16'h1010, 1'b0);

    // Backpressure: five cycles in DONE with i_ready low.
    @(negedge clk);
    run_op("bp", 16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold", {14'd0, b4.o_valid, b4.o_ready, b4.c_out, b4.o_sum},
          {14'd0, 1'b1, 1'b0, 1'b0, 16'h1000});
    end
    release_done("bp", 16'h1000, 1'b0);

    // Mid-operation reset at nibble index 2.
    @(negedge clk);
    b4.i_a = 16'h1111; b4.i_b = 16'h2222; b4.c_in = 1'b0; b4.i_valid = 1'b1;
    @(posedge clk); #1;
    b4.i_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mrst_sum", 32'(b4.o_sum), 32'd0);
    chk("mrst_cout", 32'(b4.c_out), 32'd0);
    chk("mrst_vld", 32'(b4.o_valid), 32'd0);
    chk("mrst_rdy", 32'(b4.o_ready), 32'd1);
    @(negedge clk); rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (b4.o_valid) seen = 1;
    end
    chk("mrst_novld", 32'(seen), 32'd0);
    @(negedge clk);
    run_op("after_rst", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b0);
    release_done("after_rst", 16'h0000, 1'b1);

    // Inputs changed and i_valid pulsed while running.
    @(negedge clk);
    run_op("ign", 16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0, 1'b1);
    release_done("ign", 16'hFFFF, 1'b0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (b4.o_valid) seen = 1;
    end
    chk("ign_single", 32'(seen), 32'd0);

    // Exhaustive sweep on the single-nibble instance.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          logic [4:0] e;
          e = 5'(a + b + c);
          @(negedge clk);
          b1.i_a = 4'(a); b1.i_b = 4'(b); b1.c_in = 1'(c); b1.i_valid = 1'b1;
          @(posedge clk); #1;
          b1.i_valid = 1'b0;
          b1.i_a = ~b1.i_a;
          @(posedge clk); #1;
          chk("exh", {26'd0, b1.o_valid, b1.c_out, b1.o_sum}, {26'd0, 1'b1, e});
          b1.i_ready = 1'b1;
          @(posedge clk); #1;
          b1.i_ready = 1'b0;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
